// File: rtl/token_credit_gate.sv
// Credit gate: converts a serial token stream into saturating credits granted via valid/ready.
// Optional drop statistics counter enabled by defining TOKEN_CREDIT_GATE_STATS_EN.
module token_credit_gate #(
   parameter int MAX_CREDITS  = 15,
   parameter int INIT_CREDITS = 0,
   localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a,
   input  logic          req_valid,
   output logic          req_ready,
   output logic [CW-1:0] credits,
   output logic          full,
   output logic          empty,
`ifdef TOKEN_CREDIT_GATE_STATS_EN
   output logic [15:0]   drop_cnt,
`endif
   output logic          overflow
);

   localparam logic [CW-1:0] MAX_C  = CW'(MAX_CREDITS);
   localparam logic [CW-1:0] INIT_C = CW'(INIT_CREDITS);

   generate
      if (MAX_CREDITS < 1 || MAX_CREDITS > 255) begin : g_bad_max
         $error("token_credit_gate: MAX_CREDITS must be in 1..255");
      end
      if (INIT_CREDITS < 0 || INIT_CREDITS > MAX_CREDITS) begin : g_bad_init
         $error("token_credit_gate: INIT_CREDITS must be in 0..MAX_CREDITS");
      end
   endgenerate

   // Per-cycle operation selected by {tok, fire}.
   typedef enum logic [1:0] {
      OP_IDLE    = 2'b00,
      OP_CONSUME = 2'b01,
      OP_ADD     = 2'b10,
      OP_SWAP    = 2'b11
   } op_e;

   logic [CW-1:0] credits_q, credits_d;
   logic          overflow_q, overflow_d;
   logic          tok;
   logic          fire;
   logic          drop;
   op_e           op;

   // Output decodes depend only on the credit register, never on a or req_valid.
   assign req_ready = (credits_q != '0);
   assign empty     = (credits_q == '0);
   assign full      = (credits_q == MAX_C);
   assign credits   = credits_q;
   assign overflow  = overflow_q;

   assign tok  = a;
   assign fire = req_valid & req_ready;
   assign op   = op_e'({tok, fire});

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      credits_d  = credits_q;
      overflow_d = 1'b0;
      drop       = 1'b0;
      case (op)
         OP_IDLE: ;
         OP_ADD: begin
            if (credits_q == MAX_C) begin
               drop       = 1'b1;
               overflow_d = 1'b1;
            end else begin
               credits_d = credits_q + CW'(1);
            end
         end
         // fire already implies credits_q != 0, so this cannot wrap.
         OP_CONSUME: credits_d = credits_q - CW'(1);
         OP_SWAP: ;
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits_q  <= INIT_C;
         overflow_q <= 1'b0;
      end else begin
         credits_q  <= credits_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef TOKEN_CREDIT_GATE_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != 16'hFFFF) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_q <= 16'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_token_credit_gate.sv
// Self-checking bench for token_credit_gate: directed plan steps plus random traffic vs a credit-count model.
module tb_token_credit_gate;

   localparam int MAX  = 15;
   localparam int INIT = 3;
   localparam int CW   = $clog2(MAX + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          a;
   logic          req_valid;
   logic          req_ready;
   logic [CW-1:0] credits;
   logic          full;
   logic          empty;
   logic          overflow;
`ifdef TOKEN_CREDIT_GATE_STATS_EN
   logic [15:0]   drop_cnt;
`endif

   token_credit_gate #(.MAX_CREDITS(MAX), .INIT_CREDITS(INIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .credits   (credits),
      .full      (full),
      .empty     (empty),
`ifdef TOKEN_CREDIT_GATE_STATS_EN
      .drop_cnt  (drop_cnt),
`endif
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int fires  = 0;

   // Reference model: a plain integer count of stored credits.
   int m_cred;
   bit m_ovf;
   int m_drops;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".credits"}, 32'(credits), 32'(m_cred));
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".req_ready"}, 32'(req_ready), 32'(m_cred != 0));
      check({tag, ".full"}, 32'(full), 32'(m_cred == MAX));
      check({tag, ".empty"}, 32'(empty), 32'(m_cred == 0));
`ifdef TOKEN_CREDIT_GATE_STATS_EN
      check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
`endif
   endtask

   task automatic model_reset();
      m_cred  = INIT;
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   // One clock: drive at the falling edge, advance the model, sample 1 time unit after the rising edge.
   task automatic step(input logic tok, input logic rv, input string tag);
      int n;
      bit f;
      @(negedge clk);
      a         = tok;
      req_valid = rv;
      f = rv && (m_cred > 0);
      n = m_cred + int'(tok) - int'(f);
      m_ovf = (n > MAX);
      if (m_ovf) begin
         n = MAX;
         if (m_drops < 65535) m_drops++;
      end
      if (f) fires++;
      m_cred = n;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] stream;
      a = 1'b0;
      req_valid = 1'b0;
      rst = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      rst = 1'b1;

      // Drain from 4: four fires, then req_ready stays low with no underflow.
      step(1'b1, 1'b0, "drain_load");
      fires = 0;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "drain");
      check("drain.fires", 32'(fires), 32'd4);

      // Token and request together while empty: no fire, then fire next cycle.
      fires = 0;
      step(1'b1, 1'b1, "race_first");
      check("race.no_fire", 32'(fires), 32'd0);
      step(1'b0, 1'b1, "race_second");
      check("race.fire", 32'(fires), 32'd1);

      // Fill from 0 with 17 tokens: two drops at the top.
      for (int i = 0; i < 17; i++) step(1'b1, 1'b0, "fill");
      step(1'b0, 1'b0, "fill_quiet");
      check("fill.credits_hold", 32'(credits), 32'(MAX));

      // Drop again, then reset mid-cycle while overflow is high.
      step(1'b1, 1'b0, "pre_reset_drop");
      check("pre_reset.overflow", 32'(overflow), 32'd1);
      #2;
      a = 1'b1;
      rst = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      @(posedge clk);
      #1;
      check_all("reset_held");
      @(negedge clk);
      a = 1'b0;
      rst = 1'b1;

      // Reach full, then token and request together for 5 cycles.
      for (int i = 0; i < MAX - INIT; i++) step(1'b1, 1'b0, "to_full");
      fires = 0;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "swap_full");
      check("swap.fires", 32'(fires), 32'd5);

      // Empty out, then feed the halving-stage stream.
      for (int i = 0; i < MAX + 1; i++) step(1'b0, 1'b1, "empty_out");
      stream = 16'b0100_0100_1000_0101;
      for (int i = 15; i >= 0; i--) step(stream[i], 1'b0, "stream");
      check("stream.credits", 32'(credits), 32'd5);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 40), "random");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
